// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/execute/PC-update sequencer; `define CALL_STACK_EN adds a return stack
module fetch_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int STACK_DEPTH = 4
) (
    input  logic               sys_clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               halt_req,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_en,
    output logic               do_jump,
    output logic [ADDR_W-1:0]  jump_value,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               is_call,
    input  logic               is_ret,
    output logic               busy,
    output logic               halted,
    output logic               fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_PCUPD, S_HALTED, S_FAULT
    } state_t;

    localparam int            CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 instr_valid_q;
    logic                 pc_en_q;
    logic                 do_jump_q;
    logic [ADDR_W-1:0]    jump_value_q;

    logic                 jump_d;
    logic [ADDR_W-1:0]    jval_d;
    logic                 exec_fault_d;

`ifdef CALL_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SPW-1:0]    sp_q;
    logic              push_d;
    logic              pop_d;

    always_comb begin
        jump_d       = branch_taken;
        jval_d       = branch_target;
        exec_fault_d = 1'b0;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        if (is_call && is_ret) begin
            exec_fault_d = 1'b1;
        end else if (is_call) begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
                exec_fault_d = 1'b1;
            end else begin
                push_d = 1'b1;
                jump_d = 1'b1;
            end
        end else if (is_ret) begin
            if (sp_q == '0) begin
                exec_fault_d = 1'b1;
            end else begin
                pop_d  = 1'b1;
                jump_d = 1'b1;
                jval_d = stack_q[IW'(sp_q - SPW'(1))];
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = (^{is_call, is_ret}) ^ (STACK_DEPTH == 0);

    always_comb begin
        jump_d       = branch_taken;
        jval_d       = branch_target;
        exec_fault_d = 1'b0;
    end
`endif

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_en_q       <= 1'b0;
            do_jump_q     <= 1'b0;
            jump_value_q  <= '0;
`ifdef CALL_STACK_EN
            sp_q          <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            pc_en_q       <= 1'b0;
            do_jump_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_EXEC;
                    end else if (MEM_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (exec_fault_d) begin
                            state_q <= S_FAULT;
                        end else begin
                            pc_en_q      <= 1'b1;
                            do_jump_q    <= jump_d;
                            jump_value_q <= jval_d;
                            state_q      <= S_PCUPD;
`ifdef CALL_STACK_EN
                            if (push_d) begin
                                stack_q[IW'(sp_q)] <= pc + ADDR_W'(1);
                                sp_q               <= sp_q + SPW'(1);
                            end else if (pop_d) begin
                                sp_q <= sp_q - SPW'(1);
                            end
`endif
                        end
                    end
                end
                // halt_req is only honoured here, at the instruction boundary
                S_PCUPD: begin
                    if (halt_req || !run) begin
                        state_q <= S_HALTED;
                    end else begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end
                end
                S_HALTED: begin
                    if (run && !halt_req) begin
                        state_q <= S_FETCH;
                        cnt_q   <= '0;
                    end
                end
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_en       = pc_en_q;
    assign do_jump     = do_jump_q;
    assign jump_value  = jump_value_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_PCUPD);
    assign halted      = (state_q == S_HALTED);
    assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        sys_clock = 1'b0;
    logic        reset_n;
    logic        run, halt_req;
    logic [15:0] pc_m;
    logic        pc_en, do_jump;
    logic [15:0] jump_value;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done, branch_taken, is_call, is_ret;
    logic [15:0] branch_target;
    logic        busy, halted, fault;

    int vectors    = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    always #5 sys_clock = ~sys_clock;

    fetch_sequencer dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .run(run), .halt_req(halt_req),
        .pc(pc_m), .pc_en(pc_en), .do_jump(do_jump), .jump_value(jump_value),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
        .is_call(is_call), .is_ret(is_ret), .busy(busy), .halted(halted), .fault(fault)
    );

    // program_counter stand-in
    always @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n)   pc_m <= 16'h0000;
        else if (pc_en) pc_m <= do_jump ? jump_value : pc_m + 16'h0001;
    end

    task automatic step;
        @(negedge sys_clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {25'd0, imem_req, pc_en, do_jump, instr_valid, busy, halted, fault}, 32'd0);
        chk({tag, "_instr"}, {16'd0, instr}, 32'd0);
        chk({tag, "_jval"},  {16'd0, jump_value}, 32'd0);
        chk({tag, "_addr"},  {16'd0, imem_addr}, 32'd0);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (imem_req !== 1'b1 && n < budget) begin
            step;
            n++;
        end
        chk("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data, input int delay);
        wait_req(20);
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, addr});
        repeat (delay) step;
        chk("req_held", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_q.push_back(data);
        step;
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        chk("instr_valid_hi", {31'd0, instr_valid}, 32'd1);
        chk("instr", {16'd0, instr}, {16'd0, exp_q.pop_front()});
        step;
        chk("instr_valid_lo", {31'd0, instr_valid}, 32'd0);
        chk("busy_exec", {31'd0, busy}, 32'd1);
    endtask

    task automatic exec_one(input logic br, input logic [15:0] tgt, input logic call,
                            input logic ret, input logic exp_j, input logic [15:0] exp_v);
        exec_done     = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        is_call       = call;
        is_ret        = ret;
        step;
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        is_call       = 1'b0;
        is_ret        = 1'b0;
        branch_target = 16'hBEEF;
        chk("pc_en_hi", {31'd0, pc_en}, 32'd1);
        chk("do_jump", {31'd0, do_jump}, {31'd0, exp_j});
        if (exp_j) chk("jump_value", {16'd0, jump_value}, {16'd0, exp_v});
        step;
        chk("pc_en_lo", {31'd0, pc_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset_n = 1'b0; run = 1'b0; halt_req = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        is_call = 1'b0; is_ret = 1'b0;
        step; step;
        chk_all_zero("reset");

        // plain fetch, ack two cycles late, sequential step
        reset_n = 1'b1;
        run     = 1'b1;
        fetch_one(16'h0000, 16'h1234, 2);
        exec_one(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // taken branch
        fetch_one(16'h0001, 16'hA5A5, 0);
        exec_one(1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040);

        // halt raised during EXEC still completes the PC update
        fetch_one(16'h0040, 16'h0F0F, 1);
        halt_req = 1'b1;
        exec_one(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("halted_hi", {31'd0, halted}, 32'd1);
        chk("halted_req", {31'd0, imem_req}, 32'd0);
        step; step;
        chk("halted_hold", {30'd0, halted, imem_req}, 32'd2);
        halt_req = 1'b0;
        fetch_one(16'h0041, 16'h5555, 0);
        exec_one(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // fetch timeout
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (fault === 1'b1) break;
            if (imem_req === 1'b1) cnt++;
            step;
        end
        chk("timeout_cycles", cnt, 32'd15);
        chk("fault_hi", {31'd0, fault}, 32'd1);
        chk("fault_req", {30'd0, imem_req, busy}, 32'd0);
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        step; step; step;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        chk("fault_sticky", {29'd0, fault, pc_en, instr_valid}, 32'd4);

        // reset clears fault, then reset mid-FETCH drops the request at once
        reset_n = 1'b0;
        #1;
        chk("fault_reset", {31'd0, fault}, 32'd0);
        step;
        reset_n = 1'b1;
        wait_req(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, imem_req}, 32'd0);
        chk_all_zero("mid_reset");
        step;
        run     = 1'b0;
        reset_n = 1'b1;
        step; step;
        chk_all_zero("idle_after_reset");

`ifdef CALL_STACK_EN
        run = 1'b1;
        fetch_one(16'h0000, 16'h1111, 0);
        exec_one(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005);
        fetch_one(16'h0005, 16'h2222, 0);
        exec_one(1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, 16'h0100);
        fetch_one(16'h0100, 16'h3333, 0);
        exec_one(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006);
        fetch_one(16'h0006, 16'h4444, 0);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] t;
            t = 16'h0200 + 16'(i) * 16'h0100;
            exec_one(1'b0, t, 1'b1, 1'b0, 1'b1, t);
            fetch_one(t, 16'h6000 + 16'(i), 0);
        end
        exec_done     = 1'b1;
        is_call       = 1'b1;
        branch_target = 16'h0900;
        step;
        exec_done     = 1'b0;
        is_call       = 1'b0;
        chk("stack_overflow_fault", {30'd0, fault, pc_en}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
